// File: rtl/pipelined_cla_adder_if.sv
// Handshake and operand/result bundle for the pipelined CLA adder/subtractor.
// The master side issues operands and accepts results. The slave side is the adder.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             Valid_i;
  logic             Ready_o;
  logic [WIDTH-1:0] Number1_i;
  logic [WIDTH-1:0] Number2_i;
  logic             Carry_i;
  logic             Subtract_i;
  logic             Valid_o;
  logic             Ready_i;
  logic [WIDTH-1:0] Result_o;
  logic             Carry_o;
  logic             Overflow_o;
  logic             Zero_o;

  modport master (
    output Valid_i, Number1_i, Number2_i, Carry_i, Subtract_i, Ready_i,
    input  Ready_o, Valid_o, Result_o, Carry_o, Overflow_o, Zero_o
  );

  modport slave (
    input  Valid_i, Number1_i, Number2_i, Carry_i, Subtract_i, Ready_i,
    output Ready_o, Valid_o, Result_o, Carry_o, Overflow_o, Zero_o
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one WIDTH/STAGES slice per stage, with the slice
// carry registered between stages and a global advance shared by every stage and the output.
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int BLOCK  = 4
) (
  input logic                 Clock_i,
  input logic                 Reset_i,
  pipelined_cla_adder_if.slave bus
);
  localparam int SLICE = WIDTH / STAGES;
  localparam int NGRP  = SLICE / BLOCK;
  localparam int LAST  = STAGES - 1;

  // Returns {carry_out, sum} for one slice built from BLOCK-bit lookahead groups.
  function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic             cin);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic [NGRP-1:0]  grp_g;
    logic [NGRP-1:0]  grp_p;
    logic [NGRP:0]    grp_c;
    g     = a & b;
    p     = a ^ b;
    grp_g = '0;
    grp_p = '1;
    c     = '0;
    for (int j = 0; j < NGRP; j++) begin
      for (int i = 0; i < BLOCK; i++) begin
        grp_g[j] = g[j*BLOCK+i] | (p[j*BLOCK+i] & grp_g[j]);
        grp_p[j] = grp_p[j] & p[j*BLOCK+i];
      end
    end
    grp_c[0] = cin;
    for (int j = 0; j < NGRP; j++) begin
      grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
    end
    for (int j = 0; j < NGRP; j++) begin
      c[j*BLOCK] = grp_c[j];
      for (int i = 1; i < BLOCK; i++) begin
        c[j*BLOCK+i] = g[j*BLOCK+i-1] | (p[j*BLOCK+i-1] & c[j*BLOCK+i-1]);
      end
    end
    c[SLICE] = grp_c[NGRP];
    return {c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  // The A word is consumed from the bottom while finished sum slices enter at the top, so
  // after the last stage it holds the complete result in natural bit order.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word,
                                                input logic [SLICE-1:0] slice);
    return WIDTH'({slice, word} >> SLICE);
  endfunction

  logic adv;
  logic valid_o_q, valid_o_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;

  // Inputs seen by each stage: entry for stage 0, the previous stage register otherwise.
  logic [WIDTH-1:0] a_st [STAGES];
  logic [WIDTH-1:0] b_st [STAGES];
  logic             c_st [STAGES];
  logic             v_st [STAGES];

  assign adv         = bus.Ready_i | ~valid_o_q;
  assign bus.Ready_o = adv;

  assign a_st[0] = bus.Number1_i;
  assign b_st[0] = bus.Subtract_i ? ~bus.Number2_i : bus.Number2_i;
  assign c_st[0] = bus.Carry_i ^ bus.Subtract_i;
  assign v_st[0] = bus.Valid_i;

  for (genvar k = 0; k < STAGES - 1; k++) begin : g_stage
    logic [SLICE:0]   r;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             c_q, c_d, v_q, v_d;

    assign r = cla_slice(a_st[k][SLICE-1:0], b_st[k][SLICE-1:0], c_st[k]);

    always_comb begin
      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
      v_d = v_q;
      if (adv) begin
        a_d = shift_in(a_st[k], r[SLICE-1:0]);
        b_d = b_st[k] >> SLICE;
        c_d = r[SLICE];
        v_d = v_st[k];
      end
    end

    // ---- stage k -> stage k+1 boundary ----
    always_ff @(posedge Clock_i) begin
      if (Reset_i) v_q <= 1'b0;
      else         v_q <= v_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end

    assign a_st[k+1] = a_q;
    assign b_st[k+1] = b_q;
    assign c_st[k+1] = c_q;
    assign v_st[k+1] = v_q;
  end

  logic [SLICE:0]   fin_r;
  logic [WIDTH-1:0] fin_sum;
  logic             fin_cmsb;

  assign fin_r    = cla_slice(a_st[LAST][SLICE-1:0], b_st[LAST][SLICE-1:0], c_st[LAST]);
  assign fin_sum  = shift_in(a_st[LAST], fin_r[SLICE-1:0]);
  // Carry into the MSB is recovered from the MSB's own sum = a ^ b ^ cin.
  assign fin_cmsb = fin_r[SLICE-1] ^ a_st[LAST][SLICE-1] ^ b_st[LAST][SLICE-1];

  always_comb begin
    valid_o_d = valid_o_q;
    result_d  = result_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    if (adv) begin
      valid_o_d = v_st[LAST];
      if (v_st[LAST]) begin
        result_d = fin_sum;
        carry_d  = fin_r[SLICE];
        ovf_d    = fin_cmsb ^ fin_r[SLICE];
        zero_d   = ~|fin_sum;
      end
    end
  end

  // ---- last stage -> output boundary ----
  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      valid_o_q <= 1'b0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      valid_o_q <= valid_o_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
    end
  end

  assign bus.Valid_o    = valid_o_q;
  assign bus.Result_o   = result_q;
  assign bus.Carry_o    = carry_q;
  assign bus.Overflow_o = ovf_q;
  assign bus.Zero_o     = zero_q;
endmodule
